// File: rtl/cpu_run_monitor.sv
// cpu_run_monitor: sequences processor reset, then watches the data-memory
// store bus, keeps a circular log of recent stores and reports a registered
// one-hot PASS / FAIL / TIMEOUT verdict for the run.
module cpu_run_monitor #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 32,
    parameter int RESET_CYCLES = 2,
    parameter int TIMEOUT      = 1000,
    parameter int PASS_ADDR    = 100,
    parameter int PASS_DATA    = 7,
    parameter int LOG_DEPTH    = 8,
    parameter int CNT_W        = 32
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_start,
    input  logic                         i_mem_write,
    input  logic [ADDR_W-1:0]            i_data_adr,
    input  logic [DATA_W-1:0]            i_write_data,
    output logic                         o_cpu_reset,
    output logic                         o_running,
    output logic                         o_done,
    output logic                         o_pass,
    output logic                         o_fail,
    output logic                         o_timeout,
    output logic [CNT_W-1:0]             o_cycle_count,
    output logic [CNT_W-1:0]             o_write_count,
    input  logic [$clog2(LOG_DEPTH)-1:0] i_log_rd_idx,
    output logic                         o_log_rd_valid,
    output logic [ADDR_W-1:0]            o_log_rd_adr,
    output logic [DATA_W-1:0]            o_log_rd_data
);

    localparam int LOG_W = $clog2(LOG_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HOLD    = 3'd1,
        S_RUN     = 3'd2,
        S_PASS    = 3'd3,
        S_FAIL    = 3'd4,
        S_TIMEOUT = 3'd5
    } state_t;

    state_t                r_state;
    logic [31:0]           r_hold_cnt;
    logic                  r_cpu_reset;
    logic                  r_running;
    logic                  r_done;
    logic                  r_pass;
    logic                  r_fail;
    logic                  r_timeout;
    logic [CNT_W-1:0]      r_cycle_count;
    logic [CNT_W-1:0]      r_write_count;
    logic [LOG_W-1:0]      r_wr_ptr;
    logic [LOG_W:0]        r_entries;
    logic [ADDR_W-1:0]     r_log_adr  [LOG_DEPTH];
    logic [DATA_W-1:0]     r_log_data [LOG_DEPTH];
    logic                  r_log_rd_valid;
    logic [ADDR_W-1:0]     r_log_rd_adr;
    logic [DATA_W-1:0]     r_log_rd_data;

    logic                  w_in_run;
    logic                  w_terminal;
    logic                  w_start_ok;
    logic                  w_store;
    logic                  w_sig;
    logic                  w_sig_pass;
    logic                  w_tmo;
    logic [LOG_W-1:0]      w_rd_pos;
    logic                  w_rd_valid;

    assign w_in_run   = (r_state == S_RUN);
    assign w_terminal = (r_state == S_PASS) || (r_state == S_FAIL) || (r_state == S_TIMEOUT);
    // A start pulse only (re)launches a run from idle or a finished run.
    assign w_start_ok = i_start && ((r_state == S_IDLE) || w_terminal);
    assign w_store    = w_in_run && i_mem_write;
    assign w_sig      = w_store && (i_data_adr == ADDR_W'(PASS_ADDR));
    assign w_sig_pass = (i_write_data == DATA_W'(PASS_DATA));
    assign w_tmo      = w_in_run && (r_cycle_count == CNT_W'(TIMEOUT - 1));

    // Index 0 is the newest entry, i.e. the slot just behind the write pointer.
    assign w_rd_pos   = r_wr_ptr - LOG_W'(1) - i_log_rd_idx;
    assign w_rd_valid = ({1'b0, i_log_rd_idx} < r_entries);

    // Run sequencing FSM with all status outputs registered alongside the state.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= S_IDLE;
            r_hold_cnt  <= 32'd0;
            r_cpu_reset <= 1'b1;
            r_running   <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_fail      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state    <= S_HOLD;
                        r_hold_cnt <= 32'd0;
                    end
                    r_cpu_reset <= 1'b1;
                end
                S_HOLD: begin
                    if (r_hold_cnt == 32'(RESET_CYCLES - 1)) begin
                        r_state     <= S_RUN;
                        r_cpu_reset <= 1'b0;
                        r_running   <= 1'b1;
                    end else begin
                        r_hold_cnt  <= r_hold_cnt + 32'd1;
                    end
                end
                S_RUN: begin
                    // A signature store on the final budget cycle still decides the run.
                    if (w_sig) begin
                        r_running <= 1'b0;
                        r_done    <= 1'b1;
                        if (w_sig_pass) begin
                            r_state <= S_PASS;
                            r_pass  <= 1'b1;
                        end else begin
                            r_state <= S_FAIL;
                            r_fail  <= 1'b1;
                        end
                    end else if (w_tmo) begin
                        r_state   <= S_TIMEOUT;
                        r_running <= 1'b0;
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                    end
                end
                S_PASS, S_FAIL, S_TIMEOUT: begin
                    // Processor keeps free-running here until a restart.
                    if (i_start) begin
                        r_state     <= S_HOLD;
                        r_hold_cnt  <= 32'd0;
                        r_cpu_reset <= 1'b1;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                        r_fail      <= 1'b0;
                        r_timeout   <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_hold_cnt  <= 32'd0;
                    r_cpu_reset <= 1'b1;
                    r_running   <= 1'b0;
                    r_done      <= 1'b0;
                    r_pass      <= 1'b0;
                    r_fail      <= 1'b0;
                    r_timeout   <= 1'b0;
                end
            endcase
        end
    end

    // Run cycle / store counters and log bookkeeping, cleared when a run is launched.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cycle_count <= '0;
            r_write_count <= '0;
            r_wr_ptr      <= '0;
            r_entries     <= '0;
        end else if (w_start_ok) begin
            r_cycle_count <= '0;
            r_write_count <= '0;
            r_wr_ptr      <= '0;
            r_entries     <= '0;
        end else if (w_in_run) begin
            r_cycle_count <= r_cycle_count + CNT_W'(1);
            if (i_mem_write) begin
                if (r_write_count != {CNT_W{1'b1}}) begin
                    r_write_count <= r_write_count + CNT_W'(1);
                end
                r_wr_ptr <= r_wr_ptr + LOG_W'(1);
                if (r_entries != (LOG_W + 1)'(LOG_DEPTH)) begin
                    r_entries <= r_entries + (LOG_W + 1)'(1);
                end
            end
        end
    end

    // Store log storage: oldest slot is overwritten once the buffer is full.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < LOG_DEPTH; i++) begin
                r_log_adr[i]  <= '0;
                r_log_data[i] <= '0;
            end
        end else if (w_store) begin
            r_log_adr[r_wr_ptr]  <= i_data_adr;
            r_log_data[r_wr_ptr] <= i_write_data;
        end
    end

    // Registered log read port; a same-cycle write is not visible until the next read.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_log_rd_valid <= 1'b0;
            r_log_rd_adr   <= '0;
            r_log_rd_data  <= '0;
        end else if (w_rd_valid) begin
            r_log_rd_valid <= 1'b1;
            r_log_rd_adr   <= r_log_adr[w_rd_pos];
            r_log_rd_data  <= r_log_data[w_rd_pos];
        end else begin
            r_log_rd_valid <= 1'b0;
            r_log_rd_adr   <= '0;
            r_log_rd_data  <= '0;
        end
    end

    assign o_cpu_reset    = r_cpu_reset;
    assign o_running      = r_running;
    assign o_done         = r_done;
    assign o_pass         = r_pass;
    assign o_fail         = r_fail;
    assign o_timeout      = r_timeout;
    assign o_cycle_count  = r_cycle_count;
    assign o_write_count  = r_write_count;
    assign o_log_rd_valid = r_log_rd_valid;
    assign o_log_rd_adr   = r_log_rd_adr;
    assign o_log_rd_data  = r_log_rd_data;

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Testbench for cpu_run_monitor: directed scenarios plus randomized runs
// checked against a run-level outcome model (first signature store within
// the cycle budget decides the verdict; the log is the last stores made).
module tb_cpu_run_monitor;

    localparam int RC  = 2;
    localparam int TMO = 20;
    localparam int LD  = 8;

    logic        clk;
    logic        i_reset;
    logic        i_start;
    logic        i_mem_write;
    logic [31:0] i_data_adr;
    logic [31:0] i_write_data;
    logic        o_cpu_reset;
    logic        o_running;
    logic        o_done;
    logic        o_pass;
    logic        o_fail;
    logic        o_timeout;
    logic [31:0] o_cycle_count;
    logic [31:0] o_write_count;
    logic [2:0]  i_log_rd_idx;
    logic        o_log_rd_valid;
    logic [31:0] o_log_rd_adr;
    logic [31:0] o_log_rd_data;

    int n_cmp;
    int n_bad;

    // schedule of stores indexed by RUN cycle
    logic        s_we  [0:63];
    logic [31:0] s_adr [0:63];
    logic [31:0] s_dat [0:63];
    int          s_len;

    cpu_run_monitor #(
        .DATA_W(32), .ADDR_W(32), .RESET_CYCLES(RC), .TIMEOUT(TMO),
        .PASS_ADDR(100), .PASS_DATA(7), .LOG_DEPTH(LD), .CNT_W(32)
    ) dut (
        .i_clk(clk), .i_reset(i_reset), .i_start(i_start),
        .i_mem_write(i_mem_write), .i_data_adr(i_data_adr), .i_write_data(i_write_data),
        .o_cpu_reset(o_cpu_reset), .o_running(o_running), .o_done(o_done),
        .o_pass(o_pass), .o_fail(o_fail), .o_timeout(o_timeout),
        .o_cycle_count(o_cycle_count), .o_write_count(o_write_count),
        .i_log_rd_idx(i_log_rd_idx), .o_log_rd_valid(o_log_rd_valid),
        .o_log_rd_adr(o_log_rd_adr), .o_log_rd_data(o_log_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        i_reset     = 1'b0;
        i_start     = 1'b0;
        i_mem_write = 1'b0;
        repeat (2) tick();
        i_reset = 1'b1;
        tick();
    endtask

    task automatic start_run();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (RC) tick();
    endtask

    task automatic clear_sched();
        for (int i = 0; i < 64; i++) begin
            s_we[i]  = 1'b0;
            s_adr[i] = 32'd0;
            s_dat[i] = 32'd0;
        end
        s_len = 0;
    endtask

    task automatic add_store(input int c, input logic [31:0] a, input logic [31:0] d);
        s_we[c]  = 1'b1;
        s_adr[c] = a;
        s_dat[c] = d;
        if (c + 1 > s_len) s_len = c + 1;
    endtask

    // Drive the schedule one RUN cycle at a time until the verdict appears (bounded).
    task automatic run_sched();
        int c;
        c = 0;
        while (!o_done && c < TMO + 5) begin
            if (c < s_len) begin
                i_mem_write  = s_we[c];
                i_data_adr   = s_adr[c];
                i_write_data = s_dat[c];
            end else begin
                i_mem_write  = 1'b0;
            end
            tick();
            c++;
        end
        i_mem_write = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b0;
        i_start = 1'b0;
        i_mem_write = 1'b0;
        repeat (3) tick();
        n_cmp++; if (o_cpu_reset !== 1'b1) begin n_bad++; $display("FAIL rst_cpu_reset: got %0b want 1", o_cpu_reset); end
        n_cmp++; if ({o_running, o_done, o_pass, o_fail, o_timeout} !== 5'b0) begin n_bad++; $display("FAIL rst_flags: got %b want 00000", {o_running, o_done, o_pass, o_fail, o_timeout}); end
        n_cmp++; if (o_cycle_count !== 32'd0 || o_write_count !== 32'd0) begin n_bad++; $display("FAIL rst_counts: got %0d/%0d want 0/0", o_cycle_count, o_write_count); end
        n_cmp++; if (o_log_rd_valid !== 1'b0) begin n_bad++; $display("FAIL rst_log_valid: got %0b want 0", o_log_rd_valid); end
        i_reset = 1'b1;
        tick();
        // start held over two edges: the second must be ignored in HOLD
        i_start = 1'b1;
        tick();
        n_cmp++; if (o_cpu_reset !== 1'b1 || o_running !== 1'b0) begin n_bad++; $display("FAIL hold_cyc0: got cpu_reset=%0b running=%0b want 1/0", o_cpu_reset, o_running); end
        tick();
        i_start = 1'b0;
        n_cmp++; if (o_cpu_reset !== 1'b1 || o_running !== 1'b0) begin n_bad++; $display("FAIL hold_cyc1: got cpu_reset=%0b running=%0b want 1/0", o_cpu_reset, o_running); end
        tick();
        n_cmp++; if (o_cpu_reset !== 1'b0 || o_running !== 1'b1) begin n_bad++; $display("FAIL run_entry: got cpu_reset=%0b running=%0b want 0/1", o_cpu_reset, o_running); end
        n_cmp++; if (o_cycle_count !== 32'd0) begin n_bad++; $display("FAIL run_entry_cc: got %0d want 0", o_cycle_count); end
    endtask

    task automatic test_pass();
        apply_reset();
        start_run();
        clear_sched();
        add_store(0, 32'd4, 32'd10);
        add_store(2, 32'd8, 32'd20);
        add_store(4, 32'd100, 32'd7);
        run_sched();
        n_cmp++; if ({o_pass, o_fail, o_timeout, o_done} !== 4'b1001) begin n_bad++; $display("FAIL pass_flags: got p/f/t/d=%b want 1001", {o_pass, o_fail, o_timeout, o_done}); end
        n_cmp++; if (o_write_count !== 32'd3) begin n_bad++; $display("FAIL pass_wc: got %0d want 3", o_write_count); end
        n_cmp++; if (o_cycle_count !== 32'd5) begin n_bad++; $display("FAIL pass_cc: got %0d want 5", o_cycle_count); end
        n_cmp++; if (o_running !== 1'b0 || o_cpu_reset !== 1'b0) begin n_bad++; $display("FAIL pass_run_rst: got running=%0b cpu_reset=%0b want 0/0", o_running, o_cpu_reset); end
        i_log_rd_idx = 3'd0; tick();
        n_cmp++; if (o_log_rd_valid !== 1'b1 || o_log_rd_adr !== 32'd100 || o_log_rd_data !== 32'd7) begin n_bad++; $display("FAIL pass_log0: got v=%0b (%0d,%0d) want 1 (100,7)", o_log_rd_valid, o_log_rd_adr, o_log_rd_data); end
        i_log_rd_idx = 3'd2; tick();
        n_cmp++; if (o_log_rd_valid !== 1'b1 || o_log_rd_adr !== 32'd4 || o_log_rd_data !== 32'd10) begin n_bad++; $display("FAIL pass_log2: got v=%0b (%0d,%0d) want 1 (4,10)", o_log_rd_valid, o_log_rd_adr, o_log_rd_data); end
        i_log_rd_idx = 3'd3; tick();
        n_cmp++; if (o_log_rd_valid !== 1'b0 || o_log_rd_adr !== 32'd0 || o_log_rd_data !== 32'd0) begin n_bad++; $display("FAIL pass_log3: got v=%0b (%0d,%0d) want 0 (0,0)", o_log_rd_valid, o_log_rd_adr, o_log_rd_data); end
    endtask

    task automatic test_fail();
        apply_reset();
        start_run();
        clear_sched();
        add_store(1, 32'd100, 32'd5);
        run_sched();
        n_cmp++; if ({o_pass, o_fail, o_timeout, o_done} !== 4'b0101) begin n_bad++; $display("FAIL fail_flags: got p/f/t/d=%b want 0101", {o_pass, o_fail, o_timeout, o_done}); end
        n_cmp++; if (o_write_count !== 32'd1 || o_cycle_count !== 32'd2) begin n_bad++; $display("FAIL fail_counts: got wc=%0d cc=%0d want 1/2", o_write_count, o_cycle_count); end
        // stores after the verdict must be ignored
        i_mem_write = 1'b1; i_data_adr = 32'd100; i_write_data = 32'd7;
        repeat (3) tick();
        i_mem_write = 1'b0;
        n_cmp++; if (o_pass !== 1'b0 || o_fail !== 1'b1) begin n_bad++; $display("FAIL fail_hold: got pass=%0b fail=%0b want 0/1", o_pass, o_fail); end
        n_cmp++; if (o_write_count !== 32'd1 || o_cycle_count !== 32'd2) begin n_bad++; $display("FAIL fail_post_counts: got wc=%0d cc=%0d want 1/2", o_write_count, o_cycle_count); end
        i_log_rd_idx = 3'd0; tick();
        n_cmp++; if (o_log_rd_valid !== 1'b1 || o_log_rd_data !== 32'd5) begin n_bad++; $display("FAIL fail_log0: got v=%0b data=%0d want 1/5", o_log_rd_valid, o_log_rd_data); end
        i_log_rd_idx = 3'd1; tick();
        n_cmp++; if (o_log_rd_valid !== 1'b0) begin n_bad++; $display("FAIL fail_log1: got v=%0b want 0", o_log_rd_valid); end
    endtask

    task automatic test_timeout();
        apply_reset();
        start_run();
        clear_sched();
        run_sched();
        n_cmp++; if ({o_pass, o_fail, o_timeout, o_done} !== 4'b0011) begin n_bad++; $display("FAIL tmo_flags: got p/f/t/d=%b want 0011", {o_pass, o_fail, o_timeout, o_done}); end
        n_cmp++; if (o_cycle_count !== 32'd20 || o_write_count !== 32'd0) begin n_bad++; $display("FAIL tmo_counts: got cc=%0d wc=%0d want 20/0", o_cycle_count, o_write_count); end
        // restart from terminal without reset: status and counters clear on launch
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        n_cmp++; if (o_done !== 1'b0 || o_timeout !== 1'b0 || o_cycle_count !== 32'd0 || o_cpu_reset !== 1'b1) begin n_bad++; $display("FAIL restart_clear: got d=%0b t=%0b cc=%0d cpu_reset=%0b want 0/0/0/1", o_done, o_timeout, o_cycle_count, o_cpu_reset); end
        repeat (RC) tick();
        clear_sched();
        add_store(19, 32'd100, 32'd7);
        run_sched();
        n_cmp++; if ({o_pass, o_fail, o_timeout, o_done} !== 4'b1001) begin n_bad++; $display("FAIL sig_vs_tmo: got p/f/t/d=%b want 1001", {o_pass, o_fail, o_timeout, o_done}); end
        n_cmp++; if (o_cycle_count !== 32'd20 || o_write_count !== 32'd1) begin n_bad++; $display("FAIL sig_vs_tmo_counts: got cc=%0d wc=%0d want 20/1", o_cycle_count, o_write_count); end
    endtask

    task automatic test_log_wrap();
        apply_reset();
        start_run();
        clear_sched();
        for (int i = 1; i <= 11; i++) add_store(i - 1, 32'(200 + 4 * i), 32'(i));
        run_sched();
        n_cmp++; if (o_timeout !== 1'b1 || o_write_count !== 32'd11) begin n_bad++; $display("FAIL wrap_status: got t=%0b wc=%0d want 1/11", o_timeout, o_write_count); end
        for (int k = 0; k < LD; k++) begin
            i_log_rd_idx = 3'(k);
            tick();
            n_cmp++;
            if (o_log_rd_valid !== 1'b1 || o_log_rd_data !== 32'(11 - k) || o_log_rd_adr !== 32'(200 + 4 * (11 - k))) begin
                n_bad++;
                $display("FAIL wrap_log%0d: got v=%0b (%0d,%0d) want 1 (%0d,%0d)", k, o_log_rd_valid, o_log_rd_adr, o_log_rd_data, 200 + 4 * (11 - k), 11 - k);
            end
        end
    endtask

    task automatic test_midrun_reset();
        apply_reset();
        start_run();
        i_mem_write = 1'b1; i_data_adr = 32'd8;
        for (int c = 0; c < 5; c++) begin
            i_write_data = 32'(c);
            tick();
        end
        n_cmp++; if (o_cycle_count !== 32'd5 || o_write_count !== 32'd5) begin n_bad++; $display("FAIL mid_pre: got cc=%0d wc=%0d want 5/5", o_cycle_count, o_write_count); end
        #1;
        i_reset = 1'b0;
        #1;
        n_cmp++; if (o_cpu_reset !== 1'b1 || o_running !== 1'b0) begin n_bad++; $display("FAIL mid_async: got cpu_reset=%0b running=%0b want 1/0", o_cpu_reset, o_running); end
        n_cmp++; if (o_cycle_count !== 32'd0 || o_write_count !== 32'd0) begin n_bad++; $display("FAIL mid_counts: got cc=%0d wc=%0d want 0/0", o_cycle_count, o_write_count); end
        tick();
        i_reset = 1'b1;
        i_mem_write = 1'b0;
        i_log_rd_idx = 3'd0;
        tick();
        n_cmp++; if (o_log_rd_valid !== 1'b0) begin n_bad++; $display("FAIL mid_log_empty: got v=%0b want 0", o_log_rd_valid); end
        start_run();
        clear_sched();
        add_store(0, 32'd100, 32'd7);
        run_sched();
        n_cmp++; if (o_pass !== 1'b1 || o_write_count !== 32'd1 || o_cycle_count !== 32'd1) begin n_bad++; $display("FAIL mid_rerun: got pass=%0b wc=%0d cc=%0d want 1/1/1", o_pass, o_write_count, o_cycle_count); end
    endtask

    task automatic test_random();
        logic [63:0] q[$];
        logic [31:0] exp_cc;
        logic [31:0] exp_wc;
        logic [31:0] exp_adr;
        logic [31:0] exp_dat;
        logic        exp_v;
        int          kind;   // 0 pass, 1 fail, 2 timeout
        int          r;
        apply_reset();
        for (int run = 0; run < 25; run++) begin
            clear_sched();
            s_len = $urandom_range(1, 24);
            for (int c = 0; c < s_len; c++) begin
                if ($urandom_range(0, 9) < 4) begin
                    r = $urandom_range(0, 15);
                    s_we[c] = 1'b1;
                    if (r == 0) s_adr[c] = 32'd100;
                    else if (r < 4) s_adr[c] = 32'(4 * r);
                    else begin
                        s_adr[c] = $urandom;
                        if (s_adr[c] == 32'd100) s_adr[c] = 32'd101;
                    end
                    s_dat[c] = ($urandom_range(0, 1) == 1) ? 32'd7 : 32'($urandom_range(0, 15));
                end
            end
            // outcome model: first signature store inside the budget decides
            q = {};
            kind = 2; exp_cc = 32'(TMO); exp_wc = 32'd0;
            for (int c = 0; c < TMO; c++) begin
                if (c < s_len && s_we[c]) begin
                    exp_wc = exp_wc + 32'd1;
                    q.push_back({s_adr[c], s_dat[c]});
                    if (s_adr[c] == 32'd100) begin
                        kind = (s_dat[c] == 32'd7) ? 0 : 1;
                        exp_cc = 32'(c + 1);
                        break;
                    end
                end
            end
            start_run();
            run_sched();
            n_cmp++;
            if (o_pass !== (kind == 0) || o_fail !== (kind == 1) || o_timeout !== (kind == 2) || o_done !== 1'b1) begin
                n_bad++;
                $display("FAIL rnd%0d_status: got p/f/t/d=%b want kind %0d", run, {o_pass, o_fail, o_timeout, o_done}, kind);
            end
            n_cmp++;
            if (o_cycle_count !== exp_cc || o_write_count !== exp_wc) begin
                n_bad++;
                $display("FAIL rnd%0d_counts: got cc=%0d wc=%0d want %0d/%0d", run, o_cycle_count, o_write_count, exp_cc, exp_wc);
            end
            for (int k = 0; k < LD; k++) begin
                exp_v = (k < q.size());
                {exp_adr, exp_dat} = exp_v ? q[q.size() - 1 - k] : 64'd0;
                i_log_rd_idx = 3'(k);
                tick();
                n_cmp++;
                if (o_log_rd_valid !== exp_v || o_log_rd_adr !== exp_adr || o_log_rd_data !== exp_dat) begin
                    n_bad++;
                    $display("FAIL rnd%0d_log%0d: got v=%0b (%0h,%0h) want %0b (%0h,%0h)", run, k, o_log_rd_valid, o_log_rd_adr, o_log_rd_data, exp_v, exp_adr, exp_dat);
                end
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        i_reset = 1'b0;
        i_start = 1'b0;
        i_mem_write = 1'b0;
        i_data_adr = 32'd0;
        i_write_data = 32'd0;
        i_log_rd_idx = 3'd0;
        clear_sched();
        test_reset();
        test_pass();
        test_fail();
        test_timeout();
        test_log_wrap();
        test_midrun_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
